// File: rtl/julia_pkg.sv
// julia_pkg: shared types and constants for the pipelined Julia-set iterator.
//   word_t    - signed fixed-point word (J_W bits, J_FRAC fractional bits)
//   wide_t    - signed double-width product
//   payload_t - per-stage state {done, cnt, zx, zy, cx, cy [, x, y]}
//   stage_t   - {valid, payload_t}
// Optional feature macro: JULIA_TAG_EN (adds x/y tag fields to the record).
package julia_pkg;

    localparam int J_W       = 32;
    localparam int J_FRAC    = 12;
    localparam int J_MAX_ITS = 15;
    localparam int J_ITW     = $clog2(J_MAX_ITS + 1);

    typedef logic signed [J_W-1:0]   word_t;
    typedef logic signed [2*J_W-1:0] wide_t;

    // |z|^2 escape threshold (4.0) at product scale
    localparam wide_t ESC_THRESH = wide_t'(4) <<< (2 * J_FRAC);

    typedef struct packed {
        logic             done;
        logic [J_ITW-1:0] cnt;
        word_t            zx;
        word_t            zy;
        word_t            cx;
        word_t            cy;
`ifdef JULIA_TAG_EN
        logic [10:0]      x;
        logic [10:0]      y;
`endif
    } payload_t;

    typedef struct packed {
        logic     valid;
        payload_t p;
    } stage_t;

endpackage

// File: rtl/julia_stage.sv
// julia_stage: one registered Julia iteration, record in -> record out.
//   clk  in   pixel clock
//   rst  in   asynchronous active-high reset (clears valid only)
//   src  in   stage record from the previous stage
//   dst  out  stage record after this iteration
// Optional feature macro: JULIA_TAG_EN (x/y tag carried in the record).
module julia_stage
    import julia_pkg::*;
#(
    parameter int FRAC = J_FRAC
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t src,
    output stage_t dst
);

    localparam wide_t THRESH = wide_t'(4) <<< (2 * FRAC);

    wide_t            sxx;
    wide_t            syy;
    wide_t            sxy;
    wide_t            diff;
    logic [2*J_W-1:0] sq;
    logic             escape;
    payload_t         nxt;
    payload_t         p_q;
    logic             valid_q;

    always_comb begin
        sxx  = wide_t'(src.p.zx) * wide_t'(src.p.zx);
        syy  = wide_t'(src.p.zy) * wide_t'(src.p.zy);
        sxy  = wide_t'(src.p.zx) * wide_t'(src.p.zy);
        diff = sxx - syy;
        // Both squares are non-negative and at most 2^(2W-2), so an unsigned
        // sum never overflows where a signed one could.
        sq     = $unsigned(sxx) + $unsigned(syy);
        escape = src.p.done || (sq >= $unsigned(THRESH));
        nxt    = src.p;
        if (escape) begin
            nxt.done = 1'b1;
        end else begin
            nxt.zx  = word_t'(diff >>> FRAC) + src.p.cx;
            nxt.zy  = word_t'(sxy >>> (FRAC - 1)) + src.p.cy;
            nxt.cnt = src.p.cnt + J_ITW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= src.valid;
    end

    always_ff @(posedge clk) begin
        p_q <= nxt;
    end

    assign dst = '{valid: valid_q, p: p_q};

endmodule

// File: rtl/julia_pipe.sv
// julia_pipe: fully pipelined fixed-point Julia-set iterator, one pixel per
// clock in, one escape count per clock out, fixed latency MAX_ITS+1.
//   clk        in   pixel clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   pixel on x/y/cx/cy valid this cycle
//   x, y       in   pixel coordinates (11 bits each)
//   cx, cy     in   signed fixed-point constant c, sampled with the pixel
//   out_valid  out  its (and tag) valid
//   its        out  iterations completed before escape, 0..MAX_ITS
//   out_x/y    out  pixel tag aligned with its (JULIA_TAG_EN builds only)
// Optional feature macro: JULIA_TAG_EN.
// W, FRAC and MAX_ITS must match the julia_pkg record layout.
module julia_pipe
    import julia_pkg::*;
#(
    parameter  int W       = J_W,
    parameter  int FRAC    = J_FRAC,
    parameter  int MAX_ITS = J_MAX_ITS,
    parameter  int XRES    = 1280,
    parameter  int YRES    = 720,
    parameter  int SHIFT   = 4,
    localparam int ITW     = $clog2(MAX_ITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [10:0]         x,
    input  logic [10:0]         y,
    input  logic signed [W-1:0] cx,
    input  logic signed [W-1:0] cy,
    output logic                out_valid,
    output logic [ITW-1:0]      its
`ifdef JULIA_TAG_EN
    ,
    output logic [10:0]         out_x,
    output logic [10:0]         out_y
`endif
);

    stage_t   pipe [MAX_ITS+1];
    word_t    dx;
    word_t    dy;
    logic     s0_valid;
    payload_t s0_p;

    always_comb begin
        dx = word_t'($signed({1'b0, x})) - word_t'(XRES / 2);
        dy = word_t'($signed({1'b0, y})) - word_t'(YRES / 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s0_valid <= 1'b0;
        else     s0_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        s0_p.done <= 1'b0;
        s0_p.cnt  <= '0;
        s0_p.zx   <= dx <<< SHIFT;
        s0_p.zy   <= dy <<< SHIFT;
        s0_p.cx   <= cx;
        s0_p.cy   <= cy;
`ifdef JULIA_TAG_EN
        s0_p.x    <= x;
        s0_p.y    <= y;
`endif
    end

    assign pipe[0] = '{valid: s0_valid, p: s0_p};

    for (genvar k = 1; k <= MAX_ITS; k++) begin : g_stage
        julia_stage #(
            .FRAC (FRAC)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .src (pipe[k-1]),
            .dst (pipe[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            its       <= '0;
`ifdef JULIA_TAG_EN
            out_x     <= '0;
            out_y     <= '0;
`endif
        end else begin
            out_valid <= pipe[MAX_ITS].valid;
            its       <= pipe[MAX_ITS].p.cnt;
`ifdef JULIA_TAG_EN
            out_x     <= pipe[MAX_ITS].p.x;
            out_y     <= pipe[MAX_ITS].p.y;
`endif
        end
    end

endmodule

// File: tb/tb_julia_pipe.sv
// tb_julia_pipe: directed self-checking bench for julia_pipe with default
// parameters (W=32, FRAC=12, MAX_ITS=15, SHIFT=4). Tag outputs are checked
// when JULIA_TAG_EN is defined.
module tb_julia_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [10:0]        x = '0;
    logic [10:0]        y = '0;
    logic signed [31:0] cx = '0;
    logic signed [31:0] cy = '0;
    logic               out_valid;
    logic [3:0]         its;
`ifdef JULIA_TAG_EN
    logic [10:0]        out_x;
    logic [10:0]        out_y;
`endif

    int total = 0;
    int bad   = 0;

    bit e_v   [0:127];
    int e_x   [0:127];
    int e_y   [0:127];
    int e_cx  [0:127];
    int e_cy  [0:127];
    int e_its [0:127];

    always #5 clk = ~clk;

    julia_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .cx        (cx),
        .cy        (cy),
        .out_valid (out_valid),
        .its       (its)
`ifdef JULIA_TAG_EN
        ,
        .out_x     (out_x),
        .out_y     (out_y)
`endif
    );

    // Reference iteration in 64-bit arithmetic, results wrapped to 32 bits.
    function automatic int model_its(int px, int py, int pcx, int pcy);
        longint zx = longint'(px - 640) * 16;
        longint zy = longint'(py - 360) * 16;
        longint nx;
        longint ny;
        for (int k = 0; k < 15; k++) begin
            if (zx * zx + zy * zy >= (longint'(4) << 24)) return k;
            nx = ((zx * zx - zy * zy) >>> 12) + longint'(pcx);
            ny = ((zx * zy) >>> 11) + longint'(pcy);
            zx = longint'(int'(nx));
            zy = longint'(int'(ny));
        end
        return 15;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input longint got, input longint want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s[%0d] got=%0d want=%0d", tag, idx, got, want);
        end
    endtask

    task automatic set_px(input int i, input bit v, input int px, input int py,
                          input int pcx, input int pcy);
        e_v[i]   = v;
        e_x[i]   = px;
        e_y[i]   = py;
        e_cx[i]  = pcx;
        e_cy[i]  = pcy;
        e_its[i] = model_its(px, py, pcx, pcy);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            set_px(i, 1'b1, int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)),
                   int'($urandom_range(0, 16384)) - 8192, int'($urandom_range(0, 16384)) - 8192);
    endtask

    // Drives entries 0..n-1 back to back; output seen after the edge that
    // samples entry i belongs to entry i-16.
    task automatic run_stream(input int n);
        int k;
        for (int i = 0; i < n + 16; i++) begin
            if (i < n) begin
                in_valid = e_v[i];
                x        = 11'(e_x[i]);
                y        = 11'(e_y[i]);
                cx       = e_cx[i];
                cy       = e_cy[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            k = i - 16;
            if (k < 0) begin
                chk("idle_valid", i, longint'(out_valid), 0);
            end else begin
                chk("valid", k, longint'(out_valid), longint'(e_v[k]));
                if (e_v[k]) begin
                    chk("its", k, longint'(its), longint'(e_its[k]));
`ifdef JULIA_TAG_EN
                    chk("out_x", k, longint'(out_x), longint'(e_x[k]));
                    chk("out_y", k, longint'(out_y), longint'(e_y[k]));
`endif
                end
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_valid", 0, longint'(out_valid), 0);
        chk("rst_its", 0, longint'(its), 0);
`ifdef JULIA_TAG_EN
        chk("rst_out_x", 0, longint'(out_x), 0);
        chk("rst_out_y", 0, longint'(out_y), 0);
`endif
        rst = 1'b0;
        step();

        // directed pixels with hand-computed counts
        set_px(0, 1'b1, 640, 360, 0, 0);  e_its[0] = 15; // z stays 0
        set_px(1, 1'b0, 0, 0, 0, 0);
        set_px(2, 1'b1, 0, 0, 0, 0);      e_its[2] = 0;  // escapes at stage 1
        set_px(3, 1'b1, 896, 360, 0, 0);  e_its[3] = 15; // z = 1.0 fixed point
        set_px(4, 1'b1, 897, 360, 0, 0);  e_its[4] = 8;  // 4112 -> ... -> 11028 escapes
        set_px(5, 1'b1, 1279, 719, 0, 0);
        run_stream(6);

        // random stream with three bubbles
        fill_random(100);
        e_v[10] = 1'b0;
        e_v[45] = 1'b0;
        e_v[77] = 1'b0;
        run_stream(100);

        // reset mid-stream
        fill_random(20);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            x        = 11'(e_x[i]);
            y        = 11'(e_y[i]);
            cx       = e_cx[i];
            cy       = e_cy[i];
            step();
            if (i >= 16) begin
                chk("pre_rst_valid", i - 16, longint'(out_valid), 1);
                chk("pre_rst_its", i - 16, longint'(its), longint'(e_its[i - 16]));
            end
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_async_valid", 0, longint'(out_valid), 0);
        step();
        chk("rst_edge_valid", 0, longint'(out_valid), 0);
        chk("rst_edge_its", 0, longint'(its), 0);
        rst = 1'b0;
        fill_random(12);
        e_v[3] = 1'b0;
        run_stream(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
